// File: rtl/i2c_scl_stretch_gen.sv
//==============================================================================
// Module      : i2c_scl_stretch_gen
// Description : I2C bit-clock generator. Produces a four-phase SCL period of
//               4*DIVIDER clk cycles, drives SCL open-drain and freezes the
//               phase counter while a slave stretches SCL low during the
//               SCL-high quarter. Status pulses feed the byte/bit sequencer.
//               Optional stretch timeout: define I2C_STRETCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_scl_stretch_gen #(
    parameter int DIVIDER        = 6000,
    parameter int CBITS          = 15,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TBITS          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       data_clk,
    output logic       data_clk_rise,
    output logic [1:0] phase,
    output logic       switch_range,
    output logic       stretching,
    output logic       busy,
    output logic       period_done,
    output logic       timeout
);

    // Quarter boundaries of the period, and the first count at which a low
    // synchroniser output reflects the line after SCL was released.
    localparam logic [CBITS-1:0] c_Q1       = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] c_Q2       = CBITS'(2 * DIVIDER);
    localparam logic [CBITS-1:0] c_Q3       = CBITS'(3 * DIVIDER);
    localparam logic [CBITS-1:0] c_LAST     = CBITS'(4 * DIVIDER - 1);
    localparam logic [CBITS-1:0] c_HOLD_MIN = CBITS'(2 * DIVIDER + SYNC_STAGES);

    // Elaboration-time sanity check on the parameter set.
    generate
        if ((DIVIDER <= SYNC_STAGES + 1) || (SYNC_STAGES < 2) ||
            ((2 ** CBITS) <= 4 * DIVIDER) || ((2 ** TBITS) <= TIMEOUT_CYCLES)) begin : g_bad_params
            $error("i2c_scl_stretch_gen: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] w_cnt_nxt;
    logic             w_adv;
    logic             w_pd_nxt;
    logic             w_str_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_scl_sync;
    logic                   w_in_p2;
    logic                   w_hold;
    logic                   w_to_hit;
    logic                   w_to_lock;

    logic       w_run_nxt;
    logic [1:0] w_phase_nxt;

    // Two-flop (or longer) synchroniser for the asynchronous SCL line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], scl_in};
        end
    end

    assign w_scl_sync = r_sync[SYNC_STAGES-1];

    // Stretch is honoured only once the released-high level has had time to
    // propagate through the synchroniser; earlier low samples are stale.
    assign w_in_p2 = (r_cnt >= c_Q2) && (r_cnt < c_Q3);
    assign w_hold  = (r_state == S_RUN) && w_in_p2 && (r_cnt >= c_HOLD_MIN) && !w_scl_sync;

`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [TBITS-1:0] r_tcnt;
    logic             r_timeout;

    assign w_to_hit  = w_hold && (r_tcnt == TBITS'(TIMEOUT_CYCLES - 1));
    assign w_to_lock = r_timeout;
    assign timeout   = r_timeout;

    // Stretch-length counter: counts consecutive hold cycles only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_hold && !w_to_hit) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end

    // Sticky timeout flag; released by dropping ena for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_timeout <= 1'b1;
        end else if (!ena) begin
            r_timeout <= 1'b0;
        end
    end
`else
    assign w_to_hit  = 1'b0;
    assign w_to_lock = 1'b0;
    assign timeout   = 1'b0;
`endif

    // State and phase-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state / next count: start on ena, freeze on hold, stop only at wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_adv       = 1'b0;
        w_pd_nxt    = 1'b0;
        w_str_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (ena && !w_to_lock) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_hold) begin
                    w_str_nxt = 1'b1;
                end else begin
                    w_adv = 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_pd_nxt  = 1'b1;
                        w_cnt_nxt = '0;
                        if (!ena) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == S_RUN);

    // Quarter decode of the count being written this edge.
    always_comb begin
        w_phase_nxt = 2'd0;
        if (w_run_nxt) begin
            if (w_cnt_nxt < c_Q1) begin
                w_phase_nxt = 2'd0;
            end else if (w_cnt_nxt < c_Q2) begin
                w_phase_nxt = 2'd1;
            end else if (w_cnt_nxt < c_Q3) begin
                w_phase_nxt = 2'd2;
            end else begin
                w_phase_nxt = 2'd3;
            end
        end
    end

    // Registered outputs, aligned with the count they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            scl_oe        <= 1'b0;
            data_clk      <= 1'b0;
            data_clk_rise <= 1'b0;
            phase         <= 2'd0;
            switch_range  <= 1'b0;
            stretching    <= 1'b0;
            period_done   <= 1'b0;
        end else begin
            busy          <= w_run_nxt;
            scl_oe        <= w_run_nxt && !w_phase_nxt[1];
            data_clk      <= w_run_nxt && (w_phase_nxt[1] ^ w_phase_nxt[0]);
            data_clk_rise <= w_run_nxt && w_adv && (w_cnt_nxt == c_Q1);
            phase         <= w_phase_nxt;
            switch_range  <= w_run_nxt && (w_phase_nxt == 2'd2);
            stretching    <= w_str_nxt;
            period_done   <= w_pd_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_scl_stretch_gen.sv
//==============================================================================
// Module      : tb_i2c_scl_stretch_gen
// Description : Self-checking bench for i2c_scl_stretch_gen with an
//               integer-arithmetic reference model and open-drain loopback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_scl_stretch_gen;

    localparam int D    = 4;
    localparam int SYNC = 2;
    localparam int TO   = 20;
`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       scl_in = 1'b1;
    logic       scl_oe, data_clk, data_clk_rise, switch_range, stretching;
    logic       busy, period_done, timeout;
    logic [1:0] phase;

    i2c_scl_stretch_gen #(
        .DIVIDER(D), .CBITS(6), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .TBITS(6)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .scl_in(scl_in), .scl_oe(scl_oe),
        .data_clk(data_clk), .data_clk_rise(data_clk_rise), .phase(phase),
        .switch_range(switch_range), .stretching(stretching), .busy(busy),
        .period_done(period_done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model state
    int  m_busy = 0, m_cnt = 0, m_tcnt = 0, m_holds = 0;
    bit  m_pd = 0, m_rise = 0, m_str = 0, m_to = 0, m_oe = 0;
    bit  sq[$];
    bit  slave_low = 0;
    int  cyc = 0, total = 0, passes = 0;
    int  pd_q[$];
    bit  str_seen;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    endtask

    // One clock: update model from spec rules, advance DUT, compare all outputs.
    task automatic step();
        bit s, hold, hit;
        int ph;
        logic [9:0] exp, obs;
        scl_in = (m_oe || slave_low) ? 1'b0 : 1'b1;
        if (rst) begin
            m_busy = 0; m_cnt = 0; m_tcnt = 0; m_to = 0;
            m_pd = 0; m_rise = 0; m_str = 0;
            sq.delete();
            for (int i = 0; i < SYNC; i++) sq.push_back(1'b1);
        end else begin
            s    = sq[0];
            hold = (m_busy != 0) && (m_cnt / D == 2) && (m_cnt >= 2 * D + SYNC) && !s;
            hit  = 0;
            m_pd = 0; m_rise = 0; m_str = 0;
            if (m_busy == 0) begin
                m_tcnt = 0;
                m_cnt  = 0;
                if (ena && !m_to) m_busy = 1;
            end else if (hold) begin
                m_tcnt++;
                if (TO_ON && m_tcnt == TO) begin
                    hit = 1; m_to = 1; m_busy = 0; m_cnt = 0; m_tcnt = 0;
                end else begin
                    m_str = 1; m_holds++;
                end
            end else begin
                m_tcnt = 0;
                if (m_cnt == 4 * D - 1) begin
                    m_pd = 1; m_cnt = 0;
                    if (!ena) m_busy = 0;
                end else begin
                    m_cnt++;
                    m_rise = (m_cnt == D);
                end
            end
            if (TO_ON && !hit && !ena) m_to = 0;
            sq.push_back(scl_in);
            void'(sq.pop_front());
        end
        ph   = (m_busy != 0) ? m_cnt / D : 0;
        m_oe = (m_busy != 0) && (ph < 2);
        exp  = {m_busy != 0, m_oe, (m_busy != 0) && (ph == 1 || ph == 2), m_rise,
                2'(ph), (m_busy != 0) && (ph == 2), m_str, m_pd, m_to};
        @(posedge clk);
        #1;
        cyc++;
        obs = {busy, scl_oe, data_clk, data_clk_rise, phase, switch_range,
               stretching, period_done, timeout};
        check("outputs", obs, exp);
        if (period_done) pd_q.push_back(cyc);
        if (stretching) str_seen = 1;
    endtask

    task automatic run_until_cnt(input int target, input int budget);
        int n = 0;
        while (!(m_busy != 0 && m_cnt == target) && n < budget) begin
            step();
            n++;
        end
        check("reach_cnt", {9'd0, n < budget}, 10'd1);
    endtask

    task automatic check_gap(input string tag, input int exp_gap);
        int g = -1;
        if (pd_q.size() >= 2) g = pd_q[pd_q.size()-1] - pd_q[pd_q.size()-2];
        total++;
        assert (g === exp_gap) passes++;
        else $error("FAIL %s observed_gap=%0d expected_gap=%0d", tag, g, exp_gap);
    endtask

    initial begin
        int burst = 0;
        int n;

        // Reset for two cycles
        rst = 1; ena = 0;
        step(); step();
        check("reset_state", {busy, scl_oe, data_clk, data_clk_rise, phase,
                              switch_range, stretching, period_done, timeout}, 10'd0);
        rst = 0;

        // Free-running with loopback: 16-cycle period
        ena = 1;
        pd_q.delete();
        run_until_cnt(15, 40); step();
        run_until_cnt(15, 40); step();
        check_gap("period_plain", 16);

        // Slave stretch: low for 10 cycles starting at cnt 8
        pd_q.delete();
        run_until_cnt(15, 40); step();
        run_until_cnt(8, 40);
        m_holds = 0;
        slave_low = 1;
        repeat (10) step();
        slave_low = 0;
        run_until_cnt(15, 60); step();
        check("stretch_seen", {9'd0, m_holds > 0}, 10'd1);
        check_gap("period_stretch", 16 + m_holds);

        // ena dropped mid-period: period completes, then idle
        run_until_cnt(5, 40);
        ena = 0;
        repeat (20) step();
        check("idle_after_drop", {8'd0, busy, scl_oe}, 10'd0);

        // Reset while stretching
        ena = 1;
        run_until_cnt(8, 40);
        slave_low = 1;
        n = 0;
        while (!m_str && n < 20) begin step(); n++; end
        check("stretch_before_rst", {9'd0, stretching}, 10'd1);
        rst = 1;
        step();
        check("rst_mid_stretch", {busy, scl_oe, data_clk, data_clk_rise, phase,
                                  switch_range, stretching, period_done, timeout}, 10'd0);
        rst = 0;
        slave_low = 0;

        // Low pulses where no stretch may result (phases 0, 1, 3)
        pd_q.delete();
        str_seen = 0;
        repeat (70) begin
            slave_low = (m_busy != 0) && (m_cnt / D != 2) && ((m_cnt % D) inside {1, 2});
            step();
        end
        slave_low = 0;
        check("no_stretch", {9'd0, str_seen}, 10'd0);
        check_gap("period_pulses", 16);

`ifdef I2C_STRETCH_TIMEOUT_EN
        // Permanent stretch: timeout aborts, ena ignored until dropped
        slave_low = 1;
        n = 0;
        while (!m_to && n < 200) begin step(); n++; end
        check("timeout_abort", {7'd0, timeout, busy, scl_oe}, 10'b100);
        repeat (4) step();
        ena = 0;
        step();
        check("timeout_clear", {9'd0, timeout}, 10'd0);
        ena = 1;
        slave_low = 0;
`endif

        // Randomised ena / slave-stretch / reset traffic
        for (int i = 0; i < 800; i++) begin
            ena = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 299) == 0);
            if (burst > 0) burst--;
            else if ($urandom_range(0, 11) == 0) burst = $urandom_range(1, 12);
            slave_low = (burst > 0);
            step();
        end
        rst = 0;
        slave_low = 0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
